// File: rtl/request_unit_pkg.sv
// Shared types for the request unit: sequencing state encoding.
package request_unit_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } reqstate_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/request_unit.sv
// Turns decoded MemRead/MemWrite/halt into memory request handshakes,
// generates the PC advance enable, a sticky halt and performance counters.
module request_unit
    import request_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             halt,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] dacc_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    reqstate_t state_q, state_d;
    logic      dren_d, dwen_d, halted_d;
    logic      instr_inc, dacc_inc, stall_inc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            dmemREN <= 1'b0;
            dmemWEN <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            dmemREN <= dren_d;
            dmemWEN <= dwen_d;
            halted  <= halted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dren_d    = dmemREN;
        dwen_d    = dmemWEN;
        halted_d  = halted;
        pc_en     = 1'b0;
        imemREN   = (state_q != HALTED);
        instr_inc = 1'b0;
        dacc_inc  = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            FETCH: begin
                // dhit here is spurious and deliberately ignored
                if (!ihit) begin
                    stall_inc = 1'b1;
                end else if (halt) begin
                    state_d   = HALTED;
                    halted_d  = 1'b1;
                    instr_inc = 1'b1;
                end else if (MemWrite) begin
                    state_d = DATA;
                    dwen_d  = 1'b1;
                    dren_d  = 1'b0;
                end else if (MemRead) begin
                    state_d = DATA;
                    dren_d  = 1'b1;
                    dwen_d  = 1'b0;
                end else begin
                    pc_en     = 1'b1;
                    instr_inc = 1'b1;
                end
            end
            DATA: begin
                // Request held until dhit; control inputs and ihit ignored here
                if (dhit) begin
                    pc_en     = 1'b1;
                    dren_d    = 1'b0;
                    dwen_d    = 1'b0;
                    instr_inc = 1'b1;
                    dacc_inc  = 1'b1;
                    state_d   = FETCH;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (instr_inc),
        .cnt (instr_cnt)
    );

    sat_counter #(.W(CNT_W)) u_dacc_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (dacc_inc),
        .cnt (dacc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit: two instances (32-bit and 4-bit counters)
// share stimulus; a behavioural model predicts each cycle's outputs.
module tb_request_unit;

    logic CLK = 1'b0;
    logic RST, ihit, dhit, MemRead, MemWrite, halt;

    logic        imemREN, dmemREN, dmemWEN, pc_en, halted;
    logic [31:0] instr_cnt, dacc_cnt, stall_cnt;
    logic        imemREN4, dmemREN4, dmemWEN4, pc_en4, halted4;
    logic [3:0]  instr_cnt4, dacc_cnt4, stall_cnt4;

    always #5 CLK = ~CLK;

    request_unit #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .MemRead(MemRead), .MemWrite(MemWrite), .halt(halt),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .pc_en(pc_en), .halted(halted),
        .instr_cnt(instr_cnt), .dacc_cnt(dacc_cnt), .stall_cnt(stall_cnt)
    );

    request_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .MemRead(MemRead), .MemWrite(MemWrite), .halt(halt),
        .imemREN(imemREN4), .dmemREN(dmemREN4), .dmemWEN(dmemWEN4),
        .pc_en(pc_en4), .halted(halted4),
        .instr_cnt(instr_cnt4), .dacc_cnt(dacc_cnt4), .stall_cnt(stall_cnt4)
    );

    typedef struct {
        logic   imem, ren, wen, pc, hlt;
        longint ic, dc, sc;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   errors = 0;

    // Behavioural model: abstract "waiting for data", access kind, stopped flag, counts
    bit     known   = 0;
    bit     stopped = 0;
    bit     waiting = 0;
    bit     is_wr   = 0;
    bit     is_rd   = 0;
    longint m_ic = 0, m_dc = 0, m_sc = 0;

    function automatic longint sat4(longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    task automatic cyc(input bit r, input bit ih, input bit dh,
                       input bit mr, input bit mw, input bit hl);
        exp_t e;
        @(negedge CLK);
        RST = r; ihit = ih; dhit = dh; MemRead = mr; MemWrite = mw; halt = hl;
        if (known) begin
            e.imem = !stopped;
            e.ren  = is_rd;
            e.wen  = is_wr;
            e.hlt  = stopped;
            e.pc   = !stopped && (waiting ? dh : (ih && !hl && !mr && !mw));
            e.ic = m_ic; e.dc = m_dc; e.sc = m_sc;
            exp_q.push_back(e);
        end
        if (r) begin
            known = 1; stopped = 0; waiting = 0; is_wr = 0; is_rd = 0;
            m_ic = 0; m_dc = 0; m_sc = 0;
        end else if (!stopped) begin
            if (waiting) begin
                if (dh) begin
                    m_ic++; m_dc++; waiting = 0; is_wr = 0; is_rd = 0;
                end else begin
                    m_sc++;
                end
            end else if (!ih) begin
                m_sc++;
            end else if (hl) begin
                stopped = 1; m_ic++;
            end else if (mw) begin
                waiting = 1; is_wr = 1; is_rd = 0;
            end else if (mr) begin
                waiting = 1; is_rd = 1; is_wr = 0;
            end else begin
                m_ic++;
            end
        end
    endtask

    // Monitor: compares every cycle's outputs against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imemREN",   longint'(imemREN),   longint'(e.imem));
                chk("dmemREN",   longint'(dmemREN),   longint'(e.ren));
                chk("dmemWEN",   longint'(dmemWEN),   longint'(e.wen));
                chk("pc_en",     longint'(pc_en),     longint'(e.pc));
                chk("halted",    longint'(halted),    longint'(e.hlt));
                chk("instr_cnt", longint'(instr_cnt), e.ic);
                chk("dacc_cnt",  longint'(dacc_cnt),  e.dc);
                chk("stall_cnt", longint'(stall_cnt), e.sc);
                chk("pc_en4",     longint'(pc_en4),     longint'(e.pc));
                chk("dmemREN4",   longint'(dmemREN4),   longint'(e.ren));
                chk("dmemWEN4",   longint'(dmemWEN4),   longint'(e.wen));
                chk("halted4",    longint'(halted4),    longint'(e.hlt));
                chk("imemREN4",   longint'(imemREN4),   longint'(e.imem));
                chk("instr_cnt4", longint'(instr_cnt4), sat4(e.ic));
                chk("dacc_cnt4",  longint'(dacc_cnt4),  sat4(e.dc));
                chk("stall_cnt4", longint'(stall_cnt4), sat4(e.sc));
            end
        end
    end

    initial begin
        RST = 1; ihit = 0; dhit = 0; MemRead = 0; MemWrite = 0; halt = 0;
        // reset then idle fetch stalls
        cyc(1,0,0,0,0,0); cyc(1,0,0,0,0,0);
        repeat (3) cyc(0,0,0,0,0,0);
        // back-to-back non-memory instructions
        repeat (4) cyc(0,1,0,0,0,0);
        // load with two dhit stalls, spurious dhit in FETCH beforehand
        cyc(0,0,1,0,0,0);
        cyc(0,1,0,1,0,0); cyc(0,1,0,0,0,0); cyc(0,0,0,1,1,1); cyc(0,0,1,0,0,0);
        // load and store together: write wins
        cyc(0,1,0,1,1,0); cyc(0,0,0,0,0,0); cyc(0,1,1,0,0,0);
        // store with immediate dhit (minimum latency)
        cyc(0,1,0,0,1,0); cyc(0,0,1,0,0,0);
        // halt, then ignored handshakes, then reset out of HALTED
        cyc(0,1,0,0,0,1);
        repeat (5) cyc(0,1,1,1,1,0);
        cyc(1,0,0,0,0,0);
        // reset while awaiting dhit, with dhit arriving on the same edge
        cyc(0,1,0,1,0,0); cyc(0,0,0,0,0,0); cyc(1,0,1,0,0,0);
        cyc(0,0,0,0,0,0);
        // long stall saturates the 4-bit counters
        repeat (20) cyc(0,0,0,0,0,0);
        repeat (20) cyc(0,1,0,0,0,0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(99) < 2),
                ($urandom_range(99) < 70),
                ($urandom_range(99) < 50),
                ($urandom_range(99) < 30),
                ($urandom_range(99) < 20),
                ($urandom_range(99) < 3));
        end
        cyc(0,0,0,0,0,0);
        @(negedge CLK);
        #5;
        if (exp_q.size() != 0) begin
            tests++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
- Consumer side of the control-unit signals: takes MemRead, MemWrite and halt and turns them into memory-request handshakes toward the memory controller.
- Sits between control_unit and the instruction/data memory ports.
- Issues the data request and holds it until dhit.
- Produces the PC advance enable and a sticky halt.
- Keeps saturating performance counters for retired instructions, data accesses and stall cycles.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous active-high reset
ihit  input  1  instruction memory read complete this cycle
dhit  input  1  data memory access complete this cycle
MemRead  input  1  current instruction loads (from control_unit)
MemWrite  input  1  current instruction stores (from control_unit)
halt  input  1  current instruction is HALT (from control_unit)
imemREN  output  1  instruction read enable
dmemREN  output  1  data read request, registered
dmemWEN  output  1  data write request, registered
pc_en  output  1  PC may advance this cycle, combinational
halted  output  1  sticky halt, registered
instr_cnt  output  CNT_W  retired instruction count
dacc_cnt  output  CNT_W  completed data access count
stall_cnt  output  CNT_W  stall cycle count

Behaviour:
- Clocking and reset: one clock CLK; RST is synchronous and active-high. All state changes occur on the rising edge of CLK.
- Reset values: state FETCH; dmemREN=0, dmemWEN=0, halted=0; all counters 0.
- imemREN is 1 in FETCH and DATA, and 0 in HALTED.
- States:
  - FETCH, waiting for ihit.
  - DATA, waiting for dhit.
  - HALTED, terminal.
- FETCH:
  - ihit=0: stay in FETCH; stall_cnt+1.
  - ihit=1 and halt=1: go to HALTED; halted<=1; instr_cnt+1; pc_en=0.
  - ihit=1 and MemWrite=1: go to DATA; dmemWEN<=1, dmemREN<=0. Write has priority if MemRead is also 1.
  - ihit=1 and MemRead=1 (MemWrite=0): go to DATA; dmemREN<=1.
  - ihit=1, no memory op: pc_en=1 in the same cycle; instr_cnt+1; stay in FETCH.
- DATA:
  - dmemREN/dmemWEN held stable until dhit.
  - dhit=0: stall_cnt+1.
  - dhit=1: pc_en=1 in the same cycle; dmemREN<=0, dmemWEN<=0; instr_cnt+1, dacc_cnt+1; go to FETCH.
  - Control inputs are ignored in DATA; the decoded instruction is held by the memory side.
- HALTED: sticky until RST. pc_en=0, no requests, counters frozen, ihit/dhit ignored.
- Spurious handshakes: dhit in FETCH is ignored; ihit in DATA is ignored. Neither changes state nor counters.
- Counters saturate at all-ones and never wrap. instr_cnt and dacc_cnt can both increment in the same cycle.
- pc_en expression: (FETCH & ihit & ~halt & ~MemRead & ~MemWrite) | (DATA & dhit).
- Latency: non-memory instruction retires in the ihit cycle. A load or store retires in the dhit cycle; minimum 2 cycles with ihit and dhit each arriving in their first cycle.
- RST mid-DATA: request enables drop at that edge; counters clear; next state FETCH.
- RST in HALTED: returns to FETCH.
- RST has priority over every simultaneous event.

Decomposition:
- cpu_types_pkg gains typedef enum logic [1:0] reqstate_t {FETCH, DATA, HALTED}.
- New interface request_unit_if in include/request_unit_if.vh, with modport ru matching the port list above.
- One natural sub-module: sat_counter (parameter W; inputs CLK, RST, inc; output cnt; saturating), instantiated three times.

Test Plan:
- RST=1 for 2 cycles, then RST=0, ihit=0 for 3 cycles -> after reset all outputs 0 and imemREN=1; stall_cnt=3; pc_en=0.
- ihit=1, no memory op, for 4 cycles -> pc_en=1 each of those cycles; instr_cnt=4; dacc_cnt=0.
- Load: ihit=1 with MemRead=1, then dhit=0 for 2 cycles, then dhit=1 -> dmemREN high for 3 cycles; pc_en=1 only in the dhit cycle; dacc_cnt=1, instr_cnt=1, stall_cnt=2.
- Load and store asserted together: MemRead=1 and MemWrite=1 on ihit -> dmemWEN=1, dmemREN=0; state returns to FETCH after dhit.
- Halt: ihit=1 with halt=1 -> halted=1 on next edge; imemREN=0. Then drive ihit/dhit pulses for 5 cycles -> counters unchanged and pc_en=0. Then RST -> halted=0.
- Reset and saturation: assert RST while in DATA awaiting dhit -> dmemREN=0 and state FETCH next cycle. Separately, with CNT_W=4, stall for 20 cycles -> stall_cnt saturates at 15.
